// File: rtl/morse_uart_pkg.sv
// Shared constants, FSM state type and hex font for the UART echo/display path.
package morse_uart_pkg;

  localparam int DEF_CLK_FREQ     = 100_000_000;
  localparam int DEF_BAUD_RATE    = 9600;
  localparam int DEF_SAMPLE_TICKS = 16;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  function automatic int baud_div(input int clk_freq, input int baud, input int ticks);
    return clk_freq / baud / ticks;
  endfunction

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/morse_uart_baud_gen.sv
// Free-running oversample tick generator shared by receiver and transmitter.
module baud_gen #(
  parameter int DIV = 651
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/morse_uart_rx.sv
// Oversampling 8N1 receiver; data_o holds the last frame with a valid stop bit.
module uart_rx
  import morse_uart_pkg::*;
#(
  parameter int WORD_BITS    = 8,
  parameter int SAMPLE_TICKS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic                 done_o,
  output logic [WORD_BITS-1:0] data_o
);
  localparam int SW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam int NW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [SW-1:0] TK_MID  = SW'(SAMPLE_TICKS / 2 - 1);
  localparam logic [SW-1:0] TK_LAST = SW'(SAMPLE_TICKS - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(WORD_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [WORD_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: if (!rx_i) begin
        state_d = S_START;
        s_d     = '0;
      end
      // Mid start bit: a high line here means the edge was a glitch
      S_START: if (tick_i) begin
        if (s_q == TK_MID) begin
          s_d     = '0;
          n_d     = '0;
          state_d = rx_i ? S_IDLE : S_DATA;
        end else s_d = s_q + 1'b1;
      end
      S_DATA: if (tick_i) begin
        if (s_q == TK_LAST) begin
          s_d  = '0;
          sh_d = WORD_BITS'({rx_i, sh_q} >> 1);
          if (n_q == N_LAST) state_d = S_STOP;
          else               n_d = n_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      S_STOP: if (tick_i) begin
        if (s_q == TK_LAST) state_d = S_IDLE;
        else                s_d = s_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A low stop sample is a framing error: nothing is latched or announced
  always_comb begin
    done_d = (state_q == S_STOP) && tick_i && (s_q == TK_LAST) && rx_i;
    data_d = done_d ? sh_q : data_q;
  end

  assign done_o = done_q;
  assign data_o = data_q;
endmodule

// File: rtl/morse_uart_sev_seg_mux.sv
// Scans two hex digits of a byte onto a 4-digit active-low display; upper digits blank.
module sev_seg_mux
  import morse_uart_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o
);
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]              sel;

  always_comb cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign sel = cnt_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    an_o  = 4'b1111;
    seg_o = SEG_BLANK;
    case (sel)
      2'd0: begin an_o = 4'b1110; seg_o = hex_to_seg(byte_i[3:0]); end
      2'd1: begin an_o = 4'b1101; seg_o = hex_to_seg(byte_i[7:4]); end
      2'd2: an_o = 4'b1011;
      default: an_o = 4'b0111;
    endcase
  end
endmodule

// File: rtl/morse_uart_tx.sv
// 8N1 transmitter; a frame is accepted only on a tick while idle.
module uart_tx
  import morse_uart_pkg::*;
#(
  parameter int WORD_BITS    = 8,
  parameter int SAMPLE_TICKS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic                 start_i,
  input  logic [WORD_BITS-1:0] data_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 done_o,
  output logic [WORD_BITS-1:0] data_o
);
  localparam int SW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam int NW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [SW-1:0] TK_LAST = SW'(SAMPLE_TICKS - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(WORD_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [WORD_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                 tx_q, tx_d, done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: if (start_i && tick_i) begin
        state_d = S_START;
        s_d     = '0;
        sh_d    = data_i;
      end
      S_START: if (tick_i) begin
        if (s_q == TK_LAST) begin
          state_d = S_DATA;
          s_d     = '0;
          n_d     = '0;
        end else s_d = s_q + 1'b1;
      end
      S_DATA: if (tick_i) begin
        if (s_q == TK_LAST) begin
          s_d  = '0;
          sh_d = sh_q >> 1;
          if (n_q == N_LAST) state_d = S_STOP;
          else               n_d = n_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      S_STOP: if (tick_i) begin
        if (s_q == TK_LAST) state_d = S_IDLE;
        else                s_d = s_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state so tx_o and done_o line up with state_q
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    data_d = (state_q == S_IDLE && state_d == S_START) ? data_i : data_q;
  end

  assign ready_o = (state_q == S_IDLE);
  assign tx_o    = tx_q;
  assign done_o  = done_q;
  assign data_o  = data_q;
endmodule

// File: rtl/morse_uart_top.sv
// UART echo/display top: rx synchronizer, one-entry echo holding register and wiring.
module morse_uart_top
  import morse_uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD_RATE    = DEF_BAUD_RATE,
  parameter int SAMPLE_TICKS = DEF_SAMPLE_TICKS,
  parameter int WORD_BITS    = 8,
  parameter int REFRESH_BITS = 18
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  output logic                 rx_done_o,
  output logic                 tx_done_o,
  output logic [WORD_BITS-1:0] tx_data_o,
  output logic [6:0]           sev_seg_encoded_o,
  output logic [3:0]           sev_seg_anodes_o
);
  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE, SAMPLE_TICKS);

  logic                 tick, tx_ready;
  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic                 pend_q, pend_d;
  logic [WORD_BITS-1:0] hold_q, hold_d, rx_byte;

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      pend_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
    end

  // A fresh byte wins over the clear, so a byte landing on the launch tick stays queued
  always_comb begin
    rx_meta_d = rx_i;
    rx_sync_d = rx_meta_q;
    hold_d    = rx_done_o ? rx_byte : hold_q;
    if (rx_done_o)                    pend_d = 1'b1;
    else if (pend_q && tick && tx_ready) pend_d = 1'b0;
    else                              pend_d = pend_q;
  end

  baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk_i (clk_i),
    .rst_ni(reset_i),
    .tick_o(tick)
  );

  uart_rx #(.WORD_BITS(WORD_BITS), .SAMPLE_TICKS(SAMPLE_TICKS)) u_rx (
    .clk_i (clk_i),
    .rst_ni(reset_i),
    .tick_i(tick),
    .rx_i  (rx_sync_q),
    .done_o(rx_done_o),
    .data_o(rx_byte)
  );

  uart_tx #(.WORD_BITS(WORD_BITS), .SAMPLE_TICKS(SAMPLE_TICKS)) u_tx (
    .clk_i  (clk_i),
    .rst_ni (reset_i),
    .tick_i (tick),
    .start_i(pend_q),
    .data_i (hold_q),
    .ready_o(tx_ready),
    .tx_o   (tx_o),
    .done_o (tx_done_o),
    .data_o (tx_data_o)
  );

  sev_seg_mux #(.REFRESH_BITS(REFRESH_BITS)) u_disp (
    .clk_i (clk_i),
    .rst_ni(reset_i),
    .byte_i(8'(rx_byte)),
    .seg_o (sev_seg_encoded_o),
    .an_o  (sev_seg_anodes_o)
  );
endmodule

// File: tb/tb_morse_uart_top.sv
// Directed bench: serial frames in, echoed frames decoded at mid-bit, display scan modelled per cycle.
module tb_morse_uart_top;
  localparam int CLK_FREQ = 614_400;
  localparam int BAUD     = 9600;
  localparam int TICKS    = 16;
  localparam int RB       = 6;
  localparam int DIV      = CLK_FREQ / BAUD / TICKS;  // 4 clocks per tick
  localparam int BIT      = DIV * TICKS;              // 64 clocks per bit
  localparam int FRAME    = 10 * BIT;

  logic       clk = 1'b0, reset_i = 1'b0, rx_i = 1'b1;
  logic       tx_o, rx_done_o, tx_done_o;
  logic [7:0] tx_data_o;
  logic [6:0] sev_seg_encoded_o;
  logic [3:0] sev_seg_anodes_o;

  morse_uart_top #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .SAMPLE_TICKS(TICKS),
    .WORD_BITS(8), .REFRESH_BITS(RB)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .tx_o(tx_o),
    .rx_done_o(rx_done_o), .tx_done_o(tx_done_o), .tx_data_o(tx_data_o),
    .sev_seg_encoded_o(sev_seg_encoded_o), .sev_seg_anodes_o(sev_seg_anodes_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc;
  always @(posedge clk or negedge reset_i)
    if (!reset_i) cyc <= 0;
    else          cyc <= cyc + 1;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [7:0] exp_rx [$];
  logic [7:0] exp_tx [$];
  int         exp_txc [$];
  logic [7:0] disp_byte = 8'h00;
  logic [9:0] last_bits = '0;
  logic [7:0] last_dec = '0;
  bit         mon_en = 1'b1;
  int         rx_cnt = 0, txd_cnt = 0, tx_starts = 0, tx_frames = 0;
  int         last_txdone = -1000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accepted frames feed the display model and the echo queue; the scan is checked every cycle
  initial begin : cmp
    int d;
    logic [3:0] ean;
    logic [6:0] eseg;
    forever begin
      @(negedge clk);
      if (reset_i && mon_en) begin
        if (rx_done_o) begin
          rx_cnt++;
          if (exp_rx.size() == 0) check("rx_done_unexpected", 32'(1), 32'(0));
          else begin
            disp_byte = exp_rx.pop_front();
            exp_tx.push_back(disp_byte);
            exp_txc.push_back(cyc);
          end
        end
        if (tx_done_o) txd_cnt++;
        d    = (cyc >> (RB - 2)) & 3;
        ean  = ~(4'b0001 << d);
        eseg = (d == 0) ? font[disp_byte[3:0]] : (d == 1) ? font[disp_byte[7:4]] : 7'h7F;
        check("display", 32'({sev_seg_anodes_o, sev_seg_encoded_o}), 32'({ean, eseg}));
      end
    end
  end

  // Decode every frame on tx_o at mid-bit and check it against the echo queue
  initial begin : txmon
    int c0, ec, lat_ref;
    logic [7:0] eb;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (reset_i && mon_en && tx_o == 1'b0) begin
        c0 = cyc;
        tx_starts++;
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", 32'(1), 32'(0));
          eb = 8'h00;
          ec = c0 - 1;
        end else begin
          eb = exp_tx.pop_front();
          ec = exp_txc.pop_front();
        end
        lat_ref = (ec > last_txdone) ? ec : last_txdone;
        check("echo_latency", 32'(c0 > ec && c0 <= lat_ref + DIV + 2), 32'(1));
        for (int k = 0; k < 10; k++) begin
          repeat (k == 0 ? BIT / 2 : BIT) @(negedge clk);
          bits[k] = tx_o;
          if (k == 1 && mon_en) check("tx_data_o", 32'(tx_data_o), 32'(eb));
        end
        while (mon_en && cyc < c0 + FRAME) @(negedge clk);
        if (mon_en) begin
          check("tx_done_timing", 32'(tx_done_o), 32'(1));
          check("tx_frame", 32'(bits), 32'({1'b1, eb, 1'b0}));
        end
        last_txdone = cyc;
        tx_frames++;
        last_bits = bits;
        last_dec  = bits[8:1];
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit good);
    if (good && mon_en) exp_rx.push_back(b);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (good) begin
      rx_i = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      rx_i = 1'b0;
      repeat (BIT * 3 / 4) @(negedge clk);
      rx_i = 1'b1;
      repeat (BIT / 4) @(negedge clk);
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (tx_frames < target && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("wait_tx_frames", 32'(tx_frames), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_an(input string nm, input logic [3:0] an, input logic [6:0] seg);
    int n = 0;
    while (sev_seg_anodes_o !== an && n < 8 * (1 << RB)) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'({sev_seg_anodes_o, sev_seg_encoded_o}), 32'({an, seg}));
  endtask

  initial begin : main
    int r0, s0, f0;
    repeat (5) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("rst_tx_o", 32'(tx_o), 32'(1));
    check("rst_rx_done", 32'(rx_done_o), 32'(0));
    check("rst_tx_done", 32'(tx_done_o), 32'(0));
    check("rst_tx_data", 32'(tx_data_o), 32'(0));
    check("rst_anodes", 32'(sev_seg_anodes_o), 32'(4'b1110));
    check("rst_segs", 32'(sev_seg_encoded_o), 32'(7'b1000000));
    repeat (20) @(negedge clk);

    send(8'hCC, 1'b1);
    wait_frames(1);
    check("cc_rx_count", 32'(rx_cnt), 32'(1));
    check("cc_tx_done_count", 32'(txd_cnt), 32'(1));
    check("cc_tx_data", 32'(tx_data_o), 32'(8'hCC));
    check("cc_line_bits", 32'(last_bits), 32'(10'b1110011000));

    wait_an("scan_d0", 4'b1110, 7'b1000110);
    wait_an("scan_d1", 4'b1101, 7'b1000110);
    wait_an("scan_d2", 4'b1011, 7'b1111111);
    wait_an("scan_d3", 4'b0111, 7'b1111111);

    r0 = rx_cnt;
    s0 = tx_starts;
    rx_i = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rx_i = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("glitch_no_rx", 32'(rx_cnt), 32'(r0));
    check("glitch_no_tx", 32'(tx_starts), 32'(s0));

    send(8'h3C, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("frame_err_no_rx", 32'(rx_cnt), 32'(r0));
    check("frame_err_no_tx", 32'(tx_starts), 32'(s0));
    wait_an("frame_err_disp_d1", 4'b1101, 7'b1000110);

    f0 = tx_frames;
    send(8'h41, 1'b1);
    send(8'h5A, 1'b1);
    wait_frames(f0 + 2);
    check("b2b_rx_count", 32'(rx_cnt), 32'(r0 + 2));
    check("b2b_last_decoded", 32'(last_dec), 32'(8'h5A));
    check("b2b_tx_data", 32'(tx_data_o), 32'(8'h5A));
    check("b2b_done_count", 32'(txd_cnt), 32'(tx_frames));
    check("b2b_queue_empty", 32'(exp_tx.size()), 32'(0));

    // Abort an echo mid data bits: a 0x00 frame keeps the line low there
    mon_en = 1'b0;
    send(8'h00, 1'b1);
    repeat (3 * BIT) @(negedge clk);
    check("midframe_line_low", 32'(tx_o), 32'(0));
    reset_i = 1'b0;
    #1;
    check("midrst_tx_o", 32'(tx_o), 32'(1));
    check("midrst_tx_data", 32'(tx_data_o), 32'(0));
    check("midrst_rx_done", 32'(rx_done_o), 32'(0));
    check("midrst_display", 32'({sev_seg_anodes_o, sev_seg_encoded_o}), 32'({4'b1110, 7'b1000000}));
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
